// File: rtl/rtgpu_reorder_pkg.sv
// Shared types for the tagged reorder buffer: sequence tag, FSM state, channel payload.
// TAG_SIZE is taken from the `TAG_SIZE macro (16 when not supplied).
`ifndef TAG_SIZE
`define TAG_SIZE 16
`endif

package rtgpu_reorder_pkg;

    localparam int TAG_SIZE = `TAG_SIZE;

    typedef logic [TAG_SIZE-1:0] seq_t;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } rob_state_e;

    // Stand-in for the divider result type; payload width is fixed at 32 bits.
    typedef struct packed {
        seq_t        tag;
        logic [31:0] value;
    } TaggedNormalized;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/reorder_chan_fifo.sv
// Per-channel FIFO for the reorder buffer: push/pop/flush with the head entry and its
// tag visible combinationally so the top can match heads against the expected sequence.
module reorder_chan_fifo
    import rtgpu_reorder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  TaggedNormalized wdata,
    output logic            full,
    output logic            empty,
    output TaggedNormalized head,
    output seq_t            head_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    TaggedNormalized  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign head_tag = head.tag;

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tagged_reorder_buffer.sv
// Re-emits divider results in sequence-tag order from NUM_CH channel FIFOs, with flush,
// duplicate and deadlock detection. Define REORDER_STATS_EN for emit/stall counters.
module tagged_reorder_buffer
    import rtgpu_reorder_pkg::*;
#(
    parameter int NUM_CH   = 16,
    parameter int CH_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  seq_t                         start_seq,
    input  logic [NUM_CH-1:0]            in_valid,
    input  TaggedNormalized [NUM_CH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output TaggedNormalized              out_data,
    input  logic                         out_ready,
    output seq_t                         expected_seq,
    output logic                         dup_err,
    output logic                         deadlock_err
`ifdef REORDER_STATS_EN
    ,
    output logic [31:0]                  stat_emitted,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int CH_IDX_W = ch_idx_w(NUM_CH);

    rob_state_e                   state_q, state_d;
    logic                         out_valid_q, out_valid_d;
    TaggedNormalized              out_data_q, out_data_d;
    seq_t                         expected_seq_q, expected_seq_d;
    logic                         dup_err_q, dup_err_d;
    logic                         deadlock_err_q, deadlock_err_d;

    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            empty;
    TaggedNormalized [NUM_CH-1:0] head;
    seq_t [NUM_CH-1:0]            head_tag;
    logic [NUM_CH-1:0]            hit;
    logic [NUM_CH-1:0]            pop;
    logic [CH_IDX_W-1:0]          win_idx;
    logic                         any_hit;
    logic                         dup;

    // ERR freezes intake until a flush recovers the block.
    assign in_ready = (state_q == RUN) ? ~full : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        reorder_chan_fifo #(
            .DEPTH(CH_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .push    (in_valid[i] && in_ready[i]),
            .pop     (pop[i]),
            .wdata   (in_data[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .head    (head[i]),
            .head_tag(head_tag[i])
        );
    end

    always_comb begin
        hit     = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = !empty[i] && (head_tag[i] == expected_seq_q);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = CH_IDX_W'(i);
        end
        any_hit = |hit;
        dup     = (hit & (hit - NUM_CH'(1))) != '0;
    end

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        expected_seq_d = expected_seq_q;
        dup_err_d      = dup_err_q;
        deadlock_err_d = deadlock_err_q;
        pop            = '0;
        if (flush) begin
            state_d        = RUN;
            out_valid_d    = 1'b0;
            expected_seq_d = start_seq;
        end else begin
            case (state_q)
                RUN: begin
                    if (any_hit && (!out_valid_q || out_ready)) begin
                        pop[win_idx]   = 1'b1;
                        out_valid_d    = 1'b1;
                        out_data_d     = head[win_idx];
                        expected_seq_d = expected_seq_q + seq_t'(1);
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (dup) dup_err_d = 1'b1;
                    if ((&full) && !any_hit) begin
                        state_d        = ERR;
                        deadlock_err_d = 1'b1;
                    end
                end
                ERR: begin
                    if (out_ready) out_valid_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            expected_seq_q <= '0;
            dup_err_q      <= 1'b0;
            deadlock_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            expected_seq_q <= expected_seq_d;
            dup_err_q      <= dup_err_d;
            deadlock_err_q <= deadlock_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign expected_seq = expected_seq_q;
    assign dup_err      = dup_err_q;
    assign deadlock_err = deadlock_err_q;

`ifdef REORDER_STATS_EN
    logic [31:0] stat_emitted_q, stat_emitted_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_emitted_d = stat_emitted_q;
        stat_stall_d   = stat_stall_q;
        if (flush) begin
            stat_emitted_d = '0;
            stat_stall_d   = '0;
        end else begin
            if (out_valid_q && out_ready && (stat_emitted_q != '1))
                stat_emitted_d = stat_emitted_q + 32'd1;
            if (!(&empty) && !any_hit && (stat_stall_q != '1))
                stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_emitted_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_emitted_q <= stat_emitted_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_emitted = stat_emitted_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_tagged_reorder_buffer.sv
// Scoreboard bench for tagged_reorder_buffer (8 channels, depth 4, 16-bit tags).
module tb_tagged_reorder_buffer;
    import rtgpu_reorder_pkg::*;

    localparam int NCH   = 8;
    localparam int DEPTH = 4;

    logic                      clk       = 1'b0;
    logic                      reset     = 1'b1;
    logic                      flush     = 1'b0;
    seq_t                      start_seq = '0;
    logic [NCH-1:0]            in_valid  = '0;
    TaggedNormalized [NCH-1:0] in_data   = '0;
    logic                      out_ready = 1'b0;
    logic [NCH-1:0]            in_ready;
    logic                      out_valid;
    TaggedNormalized           out_data;
    seq_t                      expected_seq;
    logic                      dup_err;
    logic                      deadlock_err;
`ifdef REORDER_STATS_EN
    logic [31:0]               stat_emitted;
    logic [31:0]               stat_stall;
`endif

    int              errors = 0;
    int              checks = 0;
    TaggedNormalized sb[$];
    TaggedNormalized exp_item;
    bit              mon_en = 1'b0;

    tagged_reorder_buffer #(
        .NUM_CH  (NCH),
        .CH_DEPTH(DEPTH)
    ) dut (
`ifdef REORDER_STATS_EN
        .stat_emitted(stat_emitted),
        .stat_stall  (stat_stall),
`endif
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .start_seq   (start_seq),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .expected_seq(expected_seq),
        .dup_err     (dup_err),
        .deadlock_err(deadlock_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic TaggedNormalized mk(input int ch, input int tag);
        TaggedNormalized t;
        t.tag   = seq_t'(tag);
        t.value = {ch[7:0], 8'h5A, tag[15:0]};
        return t;
    endfunction

    // Output scoreboard: every accepted output must be the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got tag %h value %h, scoreboard empty",
                         out_data.tag, out_data.value);
            end else begin
                exp_item = sb.pop_front();
                if (out_data !== exp_item) begin
                    errors++;
                    $display("FAIL out_order: got tag %h value %h, want tag %h value %h",
                             out_data.tag, out_data.value, exp_item.tag, exp_item.value);
                end
            end
        end
    end

    task automatic do_flush(input int seq);
        flush     = 1'b1;
        start_seq = seq_t'(seq);
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic send(input int ch, input int tag);
        int n = 0;
        in_valid[ch] = 1'b1;
        in_data[ch]  = mk(ch, tag);
        @(negedge clk);
        while (!in_ready[ch] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[ch]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ch %0d tag %h in_ready stuck at 0, want 1", ch, tag);
        end
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== '1) begin errors++; $display("FAIL rst_in_ready: got %b, want all ones", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h, want 0", out_data); end
        checks++;
        if (expected_seq !== '0) begin errors++; $display("FAIL rst_expected_seq: got %h, want 0", expected_seq); end
        checks++;
        if (dup_err !== 1'b0) begin errors++; $display("FAIL rst_dup_err: got %b, want 0", dup_err); end
        checks++;
        if (deadlock_err !== 1'b0) begin errors++; $display("FAIL rst_deadlock_err: got %b, want 0", deadlock_err); end
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_in_order();
        do_flush(0);
        for (int k = 0; k < 4; k++) sb.push_back(mk(0, k));
        fork
            begin
                in_valid[0] = 1'b1;
                in_data[0]  = mk(0, 0);
                for (int k = 1; k < 4; k++) begin
                    @(posedge clk); #1;
                    in_data[0] = mk(0, k);
                end
                @(posedge clk); #1;
                in_valid[0] = 1'b0;
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data.tag !== seq_t'(k)) begin
                        errors++;
                        $display("FAIL inorder_cycle%0d: got valid %b tag %h, want valid 1 tag %h",
                                 k, out_valid, out_data.tag, k);
                    end
                    @(negedge clk);
                end
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL inorder_idle: got out_valid %b, want 0", out_valid); end
            end
        join
        wait_drain();
        checks++;
        if (expected_seq !== seq_t'(4)) begin errors++; $display("FAIL inorder_expected_seq: got %h, want 4", expected_seq); end
    endtask

    task automatic test_scatter();
        do_flush(0);
        sb.push_back(mk(7, 0));
        sb.push_back(mk(0, 1));
        sb.push_back(mk(3, 2));
        in_valid[3] = 1'b1; in_data[3] = mk(3, 2);
        in_valid[0] = 1'b1; in_data[0] = mk(0, 1);
        in_valid[7] = 1'b1; in_data[7] = mk(7, 0);
        @(posedge clk); #1;
        in_valid = '0;
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scatter_drain: got %0d pending, want 0", sb.size()); end
        checks++;
        if (expected_seq !== seq_t'(3)) begin errors++; $display("FAIL scatter_expected_seq: got %h, want 3", expected_seq); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_flush(0);
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) sb.push_back(mk(0, k));
        for (int k = 0; k < 5; k++) send(0, k);
        in_valid[0] = 1'b1;
        in_data[0]  = mk(0, 5);
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, want 0", in_ready[0]); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, want 1", out_valid); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_data !== mk(0, 0)) begin errors++; $display("FAIL bp_hold%0d: got tag %h, want tag 0", k, out_data.tag); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready %b, want 1", in_ready[0]); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, want 0", sb.size()); end
        checks++;
        if (expected_seq !== seq_t'(6)) begin errors++; $display("FAIL bp_expected_seq: got %h, want 6", expected_seq); end
    endtask

    task automatic test_wrap();
        do_flush(16'hFFFE);
        checks++;
        if (expected_seq !== 16'hFFFE) begin errors++; $display("FAIL wrap_start: got %h, want fffe", expected_seq); end
        sb.push_back(mk(2, 16'hFFFE));
        sb.push_back(mk(2, 16'hFFFF));
        sb.push_back(mk(2, 0));
        sb.push_back(mk(2, 1));
        send(2, 16'hFFFE);
        send(2, 16'hFFFF);
        send(2, 0);
        send(2, 1);
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending, want 0", sb.size()); end
        checks++;
        if (expected_seq !== seq_t'(2)) begin errors++; $display("FAIL wrap_expected_seq: got %h, want 2", expected_seq); end
    endtask

    task automatic test_deadlock();
        do_flush(0);
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < NCH; c++) in_data[c] = mk(c, 16 + 4 * c + k);
            in_valid = '1;
            @(posedge clk); #1;
        end
        in_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (deadlock_err !== 1'b1) begin errors++; $display("FAIL dl_flag: got %b, want 1", deadlock_err); end
        checks++;
        if (in_ready !== '0) begin errors++; $display("FAIL dl_in_ready: got %b, want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dl_out_valid: got %b, want 0", out_valid); end
        @(posedge clk); #1;
        do_flush(0);
        @(negedge clk);
        checks++;
        if (deadlock_err !== 1'b1) begin errors++; $display("FAIL dl_sticky: got %b, want 1", deadlock_err); end
        checks++;
        if (in_ready !== '1) begin errors++; $display("FAIL dl_flush_in_ready: got %b, want all ones", in_ready); end
        checks++;
        if (expected_seq !== '0) begin errors++; $display("FAIL dl_flush_seq: got %h, want 0", expected_seq); end
        @(posedge clk); #1;
        sb.push_back(mk(5, 0));
        send(5, 0);
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL dl_recover: got %0d pending, want 0", sb.size()); end
    endtask

    task automatic test_dup_reset();
        do_flush(4);
        sb.push_back(mk(1, 4));
        in_valid[1] = 1'b1; in_data[1] = mk(1, 4);
        in_valid[2] = 1'b1; in_data[2] = mk(2, 4);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_flag: got %b, want 1", dup_err); end
        checks++;
        if (expected_seq !== seq_t'(5)) begin errors++; $display("FAIL dup_expected_seq: got %h, want 5", expected_seq); end
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL dup_drain: got %0d pending, want 0", sb.size()); end
        out_ready = 1'b0;
        mon_en    = 1'b0;
        send(0, 5);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midstream_valid: got %b, want 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b, want 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL mrst_out_data: got %h, want 0", out_data); end
        checks++;
        if (in_ready !== '1) begin errors++; $display("FAIL mrst_in_ready: got %b, want all ones", in_ready); end
        checks++;
        if (expected_seq !== '0) begin errors++; $display("FAIL mrst_expected_seq: got %h, want 0", expected_seq); end
        checks++;
        if (dup_err !== 1'b0) begin errors++; $display("FAIL mrst_dup_err: got %b, want 0", dup_err); end
        checks++;
        if (deadlock_err !== 1'b0) begin errors++; $display("FAIL mrst_deadlock_err: got %b, want 0", deadlock_err); end
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_scatter();
        test_backpressure();
        test_wrap();
        test_deadlock();
        test_dup_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
